seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
- Programmable serial bit-pattern detector; parametrised successor of the fixed 1-0-0-1 detector.
- Pattern, pattern length and overlap mode are loaded at runtime through a config port.
- Pulses `seq_o` for one cycle per detected occurrence and keeps a saturating match counter.
- Sits on a serial bit stream next to the receive logic; one bit consumed per enabled clock.

Parameters:
- LEN_MAX, 8: maximum pattern length in bits (>= 2).
- CNT_W, 8: width of the match counter.
- RST_PATTERN, 8'b0000_1001: pattern loaded at reset (LEN_MAX bits wide).
- RST_LEN, 4: pattern length loaded at reset.
- RST_OVERLAP, 1: overlap mode loaded at reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  input  LEN_MAX  pattern; bit [len-1] is first bit received, bit [0] is last.
- cfg_len  input  $clog2(LEN_MAX+1)  pattern length in bits.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- en  input  1  bit_i is valid and consumed this cycle.
- bit_i  input  1  serial data bit.
- cnt_clr  input  1  clear match counter.
- seq_o  output  1  one-cycle match pulse.
- match_cnt_o  output  CNT_W  saturating count of matches.
- fill_o  output  $clog2(LEN_MAX+1)  number of valid history bits (debug/verification).

Behaviour:
- Reset values (rst = 1 at a clock edge):
  - seq_o = 0, match_cnt_o = 0, fill_o = 0, history = 0.
  - pattern = RST_PATTERN, len = RST_LEN, overlap = RST_OVERLAP.
- Datapath:
  - LEN_MAX-bit history shift register; on an `en` cycle: hist <= {hist[LEN_MAX-2:0], bit_i}.
  - fill saturates at LEN_MAX.
- Match condition (evaluated on `en` cycles, using the new bit):
  - new_hist[len-1:0] == pattern[len-1:0], and
  - fill_next >= len, and
  - len != 0.
- Latency:
  - seq_o is registered; it is high in the cycle after the edge that sampled the final pattern bit.
  - seq_o is high for exactly one cycle per match. Back-to-back matches give consecutive high cycles.
- Overlap mode:
  - overlap = 1: history and fill are kept after a match. For "11" on input 111, matches occur at bit 2 and bit 3.
  - overlap = 0: fill is reset to 0 on the match cycle, so the next match needs len fresh bits.
- en = 0: bit_i is ignored; history and fill hold; seq_o = 0 in the next cycle.
- Config write (cfg_we = 1):
  - Latch pattern, len and overlap; clear history and fill.
  - seq_o = 0 in the next cycle.
  - Any bit presented in the same cycle is discarded; cfg_we has priority over en.
  - match_cnt_o is unaffected.
- Length rules:
  - cfg_len > LEN_MAX is clamped to LEN_MAX.
  - cfg_len = 0 disables detection: seq_o stays 0 and the counter stays unchanged.
  - Pattern bits above len-1 are don't-care.
- Counter:
  - Increments on each match and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority: on a cycle with both cnt_clr and a match, the counter becomes 0 and the match is not counted. seq_o still pulses for that match.
- Reset mid-operation: rst has priority over cfg_we, cnt_clr and en. All state returns to the reset values at the next edge; a pending seq_o pulse is suppressed.
- FSM:
  - State CFG: one cycle after reset or a cfg write, asserting that fill is 0.
  - State RUN: normal detection.
  - CFG -> RUN unconditionally. RUN -> CFG on cfg_we.
  - rst -> CFG (holding reset defaults).

Test Plan:
- Reset defaults, en = 1, stream 1,0,0,1,0,0,1 → seq_o pulses in the cycle after bit 4 and the cycle after bit 7 (overlap). match_cnt_o = 2.
- cfg_we: pattern 8'b0000_0011, len 2, overlap 0; stream 1,1,1,1 → pulses after bit 2 and bit 4 only, count 2. Repeat with overlap 1 → pulses after bits 2, 3 and 4, count 3.
- len 8, pattern 8'b1011_0010: feed 7 matching bits, deassert en for 3 cycles with bit_i toggling, then feed the 8th bit → one pulse, 1 cycle after the 8th bit. No pulse during the en-low cycles.
- Counter: CNT_W = 2 build, 5 matches → match_cnt_o = 3 (saturated). Assert cnt_clr on the same cycle as a 6th match → counter 0, seq_o still pulses.
- cfg_we with cfg_len = 0 → long random stream gives no pulse. Then cfg_len = 12 with LEN_MAX = 8 → behaves as len 8; first possible match no earlier than the 8th bit after the write.
- Assert rst on the edge that samples the last bit of 1-0-0-1 → no seq_o pulse. Outputs 0 and pattern back to RST_PATTERN; a subsequent 1-0-0-1 is detected.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with runtime-loadable pattern,
// length and overlap mode, a registered match pulse and a saturating match counter.
module seq_detect_prog #(
    parameter int                 LEN_MAX     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [LEN_MAX-1:0] RST_PATTERN = 8'b0000_1001,
    parameter int                 RST_LEN     = 4,
    parameter logic               RST_OVERLAP = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [LEN_MAX-1:0]             cfg_pattern,
    input  logic [$clog2(LEN_MAX+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           en,
    input  logic                           bit_i,
    input  logic                           cnt_clr,
    output logic                           seq_o,
    output logic [CNT_W-1:0]               match_cnt_o,
    output logic [$clog2(LEN_MAX+1)-1:0]   fill_o
);

    localparam int               LW        = $clog2(LEN_MAX + 1);
    localparam logic [LW-1:0]    LEN_MAX_L = LW'(LEN_MAX);
    localparam logic [LW-1:0]    RST_LEN_L = LW'(RST_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        ST_CFG,
        ST_RUN
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;

    // Only the older LEN_MAX-1 bits are stored; the newest bit is bit_i itself,
    // so the bit that would fall off the top is never needed for a compare.
    logic [LEN_MAX-2:0]   r_hist;
    logic [LW-1:0]        r_fill;
    logic [LEN_MAX-1:0]   r_pat;
    logic [LW-1:0]        r_len;
    logic                 r_ovl;
    logic                 r_seq;
    logic [CNT_W-1:0]     r_cnt;

    logic [LEN_MAX-1:0]   w_hist_nx;
    logic [LW-1:0]        w_fill_base;
    logic [LW-1:0]        w_fill_nx;
    logic [LEN_MAX-1:0]   w_mask;
    logic [LW-1:0]        w_len_clamped;
    logic                 w_match;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [LW-1:0] fill_sat_inc(input logic [LW-1:0] v);
        return (v >= LEN_MAX_L) ? LEN_MAX_L : v + 1'b1;
    endfunction

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_CFG:  w_state_nx = ST_RUN;
            ST_RUN:  w_state_nx = cfg_we ? ST_CFG : ST_RUN;
            default: w_state_nx = ST_CFG;
        endcase
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < LEN_MAX; i++) begin
            w_mask[i] = (LW'(i) < r_len);
        end
    end

    // Fill is guaranteed empty in CFG; forcing it makes that invariant structural.
    assign w_fill_base   = (r_state == ST_CFG) ? '0 : r_fill;
    assign w_fill_nx     = fill_sat_inc(w_fill_base);
    assign w_hist_nx     = {r_hist, bit_i};
    assign w_len_clamped = (cfg_len > LEN_MAX_L) ? LEN_MAX_L : cfg_len;
    assign w_match       = en && !cfg_we && (r_len != '0) && (w_fill_nx >= r_len)
                           && (((w_hist_nx ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CFG;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= RST_PATTERN;
            r_len   <= RST_LEN_L;
            r_ovl   <= RST_OVERLAP;
            r_seq   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_seq   <= w_match;
            if (cfg_we) begin
                r_pat  <= cfg_pattern;
                r_len  <= w_len_clamped;
                r_ovl  <= cfg_overlap;
                r_hist <= '0;
                r_fill <= '0;
            end else if (en) begin
                r_hist <= w_hist_nx[LEN_MAX-2:0];
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_nx;
            end
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_match) begin
                r_cnt <= cnt_sat_inc(r_cnt);
            end
        end
    end

    assign seq_o       = r_seq;
    assign match_cnt_o = r_cnt;
    assign fill_o      = r_fill;

endmodule
